jacobi_result_streamer: RTL



---
 rtl/jacobi_result_streamer_pkg.sv | 19 +
 rtl/jacobi_skid_fifo.sv | 50 +++++
 rtl/jacobi_result_streamer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/jacobi_result_streamer_pkg.sv
// Shared Jacobi constants and types used by the result streamer and its skid FIFO.
package jacobi_result_streamer_pkg;

    localparam int JACOBI_N                  = 8;
    localparam int JACOBI_OUTPUT_WORD_WIDTH  = 20;
    localparam int JACOBI_ADDR_WIDTH         = 7;
    localparam int JACOBI_N_INPUT_DATA       = JACOBI_N * (JACOBI_N + 1) / 2;
    localparam int JACOBI_V_BASE             = JACOBI_N_INPUT_DATA;
    localparam int JACOBI_N_OUTPUT_DATA      = JACOBI_N + JACOBI_N * JACOBI_N;
    localparam int JACOBI_LOG2_N_OUTPUT_DATA = 7;

    typedef enum logic [1:0] {
        IDLE,
        DIAG,
        VEC,
        DRAIN
    } jacobi_stream_state_t;

endpackage

// File: rtl/jacobi_skid_fifo.sv
// Two-entry ready/valid FIFO; count lets an upstream producer throttle its outstanding requests.
module jacobi_skid_fifo #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign s_ready = (count_q != 2'd2) || m_ready;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/jacobi_result_streamer.sv
// Reads eigenvalues (packed diagonal) then eigenvectors from the Jacobi memory and streams them out.
//
// state | meaning
// IDLE  | waiting for start_i
// DIAG  | issuing reads of the N diagonal words
// VEC   | issuing reads of the N*N eigenvector words
// DRAIN | all reads issued, waiting for the last word to handshake
module jacobi_result_streamer
    import jacobi_result_streamer_pkg::*;
#(
    parameter int N          = JACOBI_N,
    parameter int WORD_WIDTH = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int ADDR_WIDTH = JACOBI_ADDR_WIDTH,
    parameter int V_BASE     = JACOBI_V_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [WORD_WIDTH-1:0] mem_rd_data_i,
    output logic [WORD_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tuser_o,
    output logic                  m_tlast_o
);

    localparam int CNT_W    = JACOBI_LOG2_N_OUTPUT_DATA;
    localparam int LAST_IDX = N + N * N - 1;
    localparam int FW       = WORD_WIDTH + 2;

    jacobi_stream_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] step_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rd_pend_q;
    logic                  rd_user_q;
    logic                  rd_last_q;
    logic                  done_q;
    logic [FW-1:0]         fifo_out;
    logic                  fifo_s_ready;
    logic [1:0]            fifo_count;
    logic                  hs;
    logic                  rd_en;
    logic                  credit;
    logic                  cnt_diag_end;
    logic                  cnt_last;
    logic [2:0]            occ;

    assign hs           = m_tvalid_o && m_tready_i;
    // Crediting the word leaving this cycle keeps one read per cycle when tready stays high.
    assign occ          = 3'(fifo_count) + 3'(rd_pend_q) - 3'(hs);
    assign credit       = (occ < 3'd2) && fifo_s_ready;
    assign cnt_diag_end = (cnt_q == CNT_W'(N - 1));
    assign cnt_last     = (cnt_q == CNT_W'(LAST_IDX));

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = DIAG;
            end
            DIAG: begin
                rd_en = credit;
                if (rd_en && cnt_diag_end) state_d = VEC;
            end
            VEC: begin
                rd_en = credit;
                if (rd_en && cnt_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (hs && m_tlast_o) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Diagonal addresses advance by a shrinking step: 0, +N, +(N-1), ...
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            step_q    <= ADDR_WIDTH'(N);
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_user_q <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_pend_q <= rd_en;
            rd_user_q <= (state_q == VEC);
            rd_last_q <= cnt_last;
            done_q    <= (state_q == DRAIN) && hs && m_tlast_o;
            if (state_q == IDLE && start_i) begin
                addr_q <= '0;
                step_q <= ADDR_WIDTH'(N);
                cnt_q  <= '0;
            end else if (rd_en) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (state_q == DIAG) begin
                    addr_q <= cnt_diag_end ? ADDR_WIDTH'(V_BASE) : addr_q + step_q;
                    step_q <= step_q - ADDR_WIDTH'(1);
                end else begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    jacobi_skid_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .s_data ({rd_last_q, rd_user_q, mem_rd_data_i}),
        .s_valid(rd_pend_q),
        .s_ready(fifo_s_ready),
        .m_data (fifo_out),
        .m_valid(m_tvalid_o),
        .m_ready(m_tready_i),
        .count  (fifo_count)
    );

    assign mem_rd_en_o = rd_en;
    assign mem_addr_o  = addr_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign {m_tlast_o, m_tuser_o, m_tdata_o} = fifo_out;

endmodule
